// File: rtl/id_operand_stage.sv
// Decode-stage operand fetch: holds the IF instruction, reads the register file,
// merges EX/MEM/WB bypasses and stalls on load-use / outstanding AXI loads.
module id_operand_stage #(
  parameter int DW  = 32,
  parameter int AW  = 5,
  parameter int PCW = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    fs_to_ds_valid,
  input  logic [PCW+31:0]         fs_to_ds_bus,
  output logic                    ds_allowin,
  input  logic                    es_allowin,
  output logic                    ds_to_es_valid,
  output logic [PCW+32+2*DW-1:0]  ds_to_es_bus,
  output logic [AW-1:0]           rf_raddr1,
  output logic [AW-1:0]           rf_raddr2,
  input  logic [DW-1:0]           rf_rdata1,
  input  logic [DW-1:0]           rf_rdata2,
  input  logic                    es_we,
  input  logic [AW-1:0]           es_waddr,
  input  logic [DW-1:0]           es_wdata,
  input  logic                    es_is_load,
  input  logic                    ms_we,
  input  logic [AW-1:0]           ms_waddr,
  input  logic [DW-1:0]           ms_wdata,
  input  logic                    ms_is_load,
  input  logic                    ms_data_ok,
  input  logic                    ws_we,
  input  logic [AW-1:0]           ws_waddr,
  input  logic [DW-1:0]           ws_wdata,
  output logic [31:0]             ds_stall_cnt
);

  logic               ds_valid;
  logic [PCW+31:0]    ds_bus_r;
  logic [31:0]        inst;
  logic [PCW-1:0]     pc;
  logic [1:0][AW-1:0] src_addr;
  logic [1:0][DW-1:0] src_rdata;
  logic [1:0][DW-1:0] src_value;
  logic [1:0]         src_stall;
  logic               stall;
  logic               ds_ready_go;

  assign inst = ds_bus_r[31:0];
  assign pc   = ds_bus_r[PCW+31:32];

  assign rf_raddr1 = inst[25:21];
  assign rf_raddr2 = inst[20:16];

  assign src_addr[0]  = rf_raddr1;
  assign src_addr[1]  = rf_raddr2;
  assign src_rdata[0] = rf_rdata1;
  assign src_rdata[1] = rf_rdata2;

  // First matching stage wins; a non-load EX match masks any pending MEM load.
  always_comb begin
    src_value = '0;
    src_stall = '0;
    for (int unsigned i = 0; i < 2; i++) begin
      if (src_addr[i] == '0) begin
        src_value[i] = '0;
      end else if (es_we && (es_waddr == src_addr[i])) begin
        src_value[i] = es_wdata;
        src_stall[i] = es_is_load;
      end else if (ms_we && (ms_waddr == src_addr[i])) begin
        src_value[i] = ms_wdata;
        src_stall[i] = ms_is_load & ~ms_data_ok;
      end else if (ws_we && (ws_waddr == src_addr[i])) begin
        src_value[i] = ws_wdata;
      end else begin
        src_value[i] = src_rdata[i];
      end
    end
  end

  assign stall          = ds_valid & (|src_stall);
  assign ds_ready_go    = ~stall;
  assign ds_allowin     = ~ds_valid | (ds_ready_go & es_allowin);
  assign ds_to_es_valid = ds_valid & ds_ready_go & ~flush;
  assign ds_to_es_bus   = {pc, inst, src_value[0], src_value[1]};

  always_ff @(posedge clk) begin
    if (reset) begin
      ds_valid     <= 1'b0;
      ds_bus_r     <= '0;
      ds_stall_cnt <= '0;
    end else begin
      if (flush) begin
        ds_valid <= 1'b0;
      end else if (ds_allowin) begin
        ds_valid <= fs_to_ds_valid;
        if (fs_to_ds_valid) begin
          ds_bus_r <= fs_to_ds_bus;
        end
      end
      if (stall && !flush) begin
        ds_stall_cnt <= ds_stall_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_id_operand_stage.sv
// Directed bench for id_operand_stage: reset, bypass priority, load-use stalls,
// backpressure/flush and same-cycle WB bypass, checked with immediate assertions.
module tb_id_operand_stage;

  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int PCW = 32;

  logic                   clk = 1'b0;
  logic                   reset, flush, fs_to_ds_valid, es_allowin;
  logic [PCW+31:0]        fs_to_ds_bus;
  logic                   ds_allowin, ds_to_es_valid;
  logic [PCW+32+2*DW-1:0] ds_to_es_bus;
  logic [AW-1:0]          rf_raddr1, rf_raddr2;
  logic [DW-1:0]          rf_rdata1, rf_rdata2;
  logic                   es_we, es_is_load, ms_we, ms_is_load, ms_data_ok, ws_we;
  logic [AW-1:0]          es_waddr, ms_waddr, ws_waddr;
  logic [DW-1:0]          es_wdata, ms_wdata, ws_wdata;
  logic [31:0]            ds_stall_cnt;

  logic [DW-1:0] rf [32];
  int passed = 0;
  int total  = 0;
  int issues = 0;
  int n0;

  always #5 clk = ~clk;

  always_comb begin
    rf_rdata1 = rf[rf_raddr1];
    rf_rdata2 = rf[rf_raddr2];
  end

  always @(posedge clk) if (ds_to_es_valid && es_allowin) issues++;

  id_operand_stage #(.DW(DW), .AW(AW), .PCW(PCW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .fs_to_ds_valid(fs_to_ds_valid), .fs_to_ds_bus(fs_to_ds_bus),
    .ds_allowin(ds_allowin), .es_allowin(es_allowin),
    .ds_to_es_valid(ds_to_es_valid), .ds_to_es_bus(ds_to_es_bus),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .es_we(es_we), .es_waddr(es_waddr), .es_wdata(es_wdata), .es_is_load(es_is_load),
    .ms_we(ms_we), .ms_waddr(ms_waddr), .ms_wdata(ms_wdata), .ms_is_load(ms_is_load),
    .ms_data_ok(ms_data_ok),
    .ws_we(ws_we), .ws_waddr(ws_waddr), .ws_wdata(ws_wdata),
    .ds_stall_cnt(ds_stall_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic logic [31:0] mk_inst(input logic [4:0] rs, input logic [4:0] rt);
    return {6'd0, rs, rt, 5'd10, 5'd0, 6'h21};
  endfunction

  task automatic load(input logic [31:0] pc, input logic [31:0] inst);
    fs_to_ds_valid = 1'b1;
    fs_to_ds_bus   = {pc, inst};
    tick();
    fs_to_ds_valid = 1'b0;
  endtask

  function automatic logic [31:0] f_pc();
    return ds_to_es_bus[127:96];
  endfunction
  function automatic logic [31:0] f_rs();
    return ds_to_es_bus[63:32];
  endfunction
  function automatic logic [31:0] f_rt();
    return ds_to_es_bus[31:0];
  endfunction

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = '0;
    rf[5] = 32'h1; rf[8] = 32'h11; rf[9] = 32'h99; rf[10] = 32'h33;
    reset = 1'b1; flush = 1'b0; fs_to_ds_valid = 1'b0; fs_to_ds_bus = '0; es_allowin = 1'b1;
    es_we = 0; es_waddr = '0; es_wdata = '0; es_is_load = 0;
    ms_we = 0; ms_waddr = '0; ms_wdata = '0; ms_is_load = 0; ms_data_ok = 0;
    ws_we = 0; ws_waddr = '0; ws_wdata = '0;

    // Reset
    tick(); tick();
    reset = 1'b0;
    settle();
    chk("rst_valid", ds_to_es_valid, 0);
    chk("rst_allowin", ds_allowin, 1);
    chk("rst_cnt", ds_stall_cnt, 0);
    chk("rst_raddr1", rf_raddr1, 0);

    // Plain register file read
    load(32'hBFC0_0000, mk_inst(5'd8, 5'd0));
    settle();
    chk("plain_valid", ds_to_es_valid, 1);
    chk("plain_raddr1", rf_raddr1, 8);
    chk("plain_rs", f_rs(), 32'h11);
    chk("plain_rt", f_rt(), 0);
    chk("plain_pc", f_pc(), 32'hBFC0_0000);

    // Bypass priority ES > MS > WS > rf
    load(32'h4, mk_inst(5'd9, 5'd0));
    es_we = 1; es_waddr = 5'd9; es_wdata = 32'hA;
    ms_we = 1; ms_waddr = 5'd9; ms_wdata = 32'hB;
    ws_we = 1; ws_waddr = 5'd9; ws_wdata = 32'hC;
    settle();
    chk("prio_es", f_rs(), 32'hA);
    es_we = 0; settle();
    chk("prio_ms", f_rs(), 32'hB);
    ms_we = 0; settle();
    chk("prio_ws", f_rs(), 32'hC);
    ws_we = 0; settle();
    chk("prio_rf", f_rs(), 32'h99);

    // $0 never bypasses and never stalls
    load(32'h8, mk_inst(5'd0, 5'd0));
    es_we = 1; es_waddr = 5'd0; es_wdata = 32'hDEAD; es_is_load = 1;
    settle();
    chk("zero_rs", f_rs(), 0);
    chk("zero_nostall", ds_to_es_valid, 1);
    es_we = 0; es_is_load = 0;

    // Load-use: 1 cycle EX load, then 3 cycles MEM load awaiting data
    load(32'hC, mk_inst(5'd10, 5'd0));
    es_we = 1; es_waddr = 5'd10; es_wdata = 32'hBAD; es_is_load = 1;
    settle();
    chk("lu_es_valid", ds_to_es_valid, 0);
    chk("lu_es_allowin", ds_allowin, 0);
    chk("lu_cnt0", ds_stall_cnt, 0);
    tick();
    es_we = 0; es_is_load = 0;
    ms_we = 1; ms_waddr = 5'd10; ms_wdata = 32'hBAD; ms_is_load = 1; ms_data_ok = 0;
    settle();
    chk("lu_cnt1", ds_stall_cnt, 1);
    chk("lu_ms_valid", ds_to_es_valid, 0);
    tick(); tick(); tick();
    ms_data_ok = 1; ms_wdata = 32'h55;
    settle();
    chk("lu_issue_valid", ds_to_es_valid, 1);
    chk("lu_issue_rs", f_rs(), 32'h55);
    chk("lu_cnt4", ds_stall_cnt, 4);
    tick();
    ms_we = 0; ms_is_load = 0; ms_data_ok = 0;
    settle();
    chk("lu_cnt_hold", ds_stall_cnt, 4);
    chk("lu_drained", ds_to_es_valid, 0);

    // Backpressure holds the bus; one handshake on release
    es_allowin = 0;
    load(32'h100, mk_inst(5'd8, 5'd0));
    fs_to_ds_valid = 1; fs_to_ds_bus = {32'h200, mk_inst(5'd5, 5'd0)};
    settle();
    chk("bp_valid", ds_to_es_valid, 1);
    chk("bp_allowin", ds_allowin, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bp_hold_pc", f_pc(), 32'h100);
    end
    n0 = issues;
    es_allowin = 1;
    tick();
    fs_to_ds_valid = 0; es_allowin = 0;
    settle();
    chk("bp_issue_once", issues, n0 + 1);
    chk("bp_next_pc", f_pc(), 32'h200);

    // Flush during hold wins over a new IF instruction
    flush = 1; fs_to_ds_valid = 1; fs_to_ds_bus = {32'h300, mk_inst(5'd8, 5'd0)};
    settle();
    chk("fl_comb_valid", ds_to_es_valid, 0);
    tick();
    flush = 0; fs_to_ds_valid = 0; es_allowin = 1;
    settle();
    chk("fl_valid", ds_to_es_valid, 0);
    chk("fl_allowin", ds_allowin, 1);
    chk("fl_no_issue", issues, n0 + 1);

    // Same-cycle WB write wins over stale register file data
    load(32'h400, mk_inst(5'd0, 5'd5));
    ws_we = 1; ws_waddr = 5'd5; ws_wdata = 32'h77;
    settle();
    chk("wb_raddr2", rf_raddr2, 5);
    chk("wb_rt", f_rt(), 32'h77);
    ws_we = 0;

    // Reset mid-stall
    load(32'h500, mk_inst(5'd10, 5'd0));
    es_we = 1; es_waddr = 5'd10; es_is_load = 1;
    tick();
    settle();
    chk("mr_cnt_pre", ds_stall_cnt, 5);
    reset = 1;
    tick();
    reset = 0; es_we = 0; es_is_load = 0;
    settle();
    chk("mr_valid", ds_to_es_valid, 0);
    chk("mr_allowin", ds_allowin, 1);
    chk("mr_cnt", ds_stall_cnt, 0);
    chk("mr_raddr1", rf_raddr1, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
